// File: rtl/ospfb_run_sequencer.sv
// Run-control sequencer for the oversampled PFB: config beat, run, clean stop on frame boundary, fault hold.
// Optional drain watchdog is enabled by defining OSPFB_SEQ_WATCHDOG_EN.
module ospfb_run_sequencer #(
    parameter int unsigned FFT_LEN     = 64,
    parameter int unsigned DEC_FAC     = 48,
    parameter int unsigned CONF_WID    = 8,
    parameter int unsigned CNT_WID     = 32,
    parameter int unsigned OVF_WID     = 16,
    parameter int unsigned WDOG_CYCLES = 4096
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [CONF_WID-1:0]        cfg_word,
    input  logic                       clear_fault,
    output logic [CONF_WID-1:0]        m_axis_cfg_tdata,
    output logic                       m_axis_cfg_tvalid,
    input  logic                       m_axis_cfg_tready,
    output logic                       ospfb_en,
    input  logic                       mon_tvalid,
    input  logic                       mon_tready,
    input  logic                       mon_tlast,
    input  logic                       event_fft_overflow,
    input  logic                       event_tlast_unexpected,
    input  logic                       event_tlast_missing,
    output logic                       busy,
    output logic                       fault,
    output logic [1:0]                 fault_code,
    output logic [$clog2(FFT_LEN)-1:0] phase,
    output logic [CNT_WID-1:0]         frame_count,
    output logic [OVF_WID-1:0]         ovf_count
);

    localparam int unsigned PH_W = $clog2(FFT_LEN);
    localparam int unsigned PS_W = PH_W + 1;
    localparam int unsigned WD_W = $clog2(WDOG_CYCLES + 1);

    // Reject illegal parameterisations at elaboration
    if (DEC_FAC == 0 || DEC_FAC >= FFT_LEN || (FFT_LEN & (FFT_LEN - 1)) != 0 ||
        WDOG_CYCLES == 0 || WD_W == 0) begin : g_param_check
        $error("ospfb_run_sequencer: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONFIG,
        S_RUN,
        S_DRAIN,
        S_FAULT
    } state_t;

    state_t              state_q, state_d;
    logic [CONF_WID-1:0] tdata_q, tdata_d;
    logic                tvalid_q, tvalid_d;
    logic                ospfb_en_q, ospfb_en_d;
    logic                busy_q, busy_d;
    logic                fault_q, fault_d;
    logic [1:0]          fault_code_q, fault_code_d;
    logic [PH_W-1:0]     phase_q, phase_d;
    logic [CNT_WID-1:0]  frame_count_q, frame_count_d;
    logic [OVF_WID-1:0]  ovf_count_q, ovf_count_d;
    logic                frame_end;
    logic                framing_evt;
    logic [PS_W-1:0]     phase_sum;
    logic [PH_W-1:0]     phase_adv;
`ifdef OSPFB_SEQ_WATCHDOG_EN
    logic [WD_W-1:0]     wdog_q, wdog_d;
    logic                wdog_hit;
`endif

    assign frame_end   = mon_tvalid & mon_tready & mon_tlast;
    assign framing_evt = event_tlast_unexpected | event_tlast_missing;
    assign phase_sum   = {1'b0, phase_q} + PS_W'(DEC_FAC);
    assign phase_adv   = (phase_sum >= PS_W'(FFT_LEN)) ? PH_W'(phase_sum - PS_W'(FFT_LEN))
                                                       : PH_W'(phase_sum);
`ifdef OSPFB_SEQ_WATCHDOG_EN
    assign wdog_hit    = (wdog_q == WD_W'(WDOG_CYCLES - 1));
`endif

    // Next-state and registered-output computation
    always_comb begin
        state_d       = state_q;
        tdata_d       = tdata_q;
        fault_code_d  = fault_code_q;
        phase_d       = phase_q;
        frame_count_d = frame_count_q;
        ovf_count_d   = ovf_count_q;
`ifdef OSPFB_SEQ_WATCHDOG_EN
        wdog_d        = wdog_q;
`endif

        if (event_fft_overflow && (ovf_count_q != {OVF_WID{1'b1}})) begin
            ovf_count_d = ovf_count_q + OVF_WID'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d       = S_CONFIG;
                    tdata_d       = cfg_word;
                    phase_d       = '0;
                    frame_count_d = '0;
                end
            end
            S_CONFIG: begin
                if (tvalid_q && m_axis_cfg_tready) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (framing_evt) begin
                    state_d      = S_FAULT;
                    fault_code_d = event_tlast_unexpected ? 2'd1 : 2'd2;
                end else begin
                    if (frame_end) begin
                        phase_d       = phase_adv;
                        frame_count_d = frame_count_q + CNT_WID'(1);
                    end
                    if (!en) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (framing_evt) begin
                    state_d      = S_FAULT;
                    fault_code_d = event_tlast_unexpected ? 2'd1 : 2'd2;
                end else if (frame_end) begin
                    state_d       = S_IDLE;
                    phase_d       = phase_adv;
                    frame_count_d = frame_count_q + CNT_WID'(1);
`ifdef OSPFB_SEQ_WATCHDOG_EN
                end else if (wdog_hit) begin
                    state_d      = S_FAULT;
                    fault_code_d = 2'd3;
`endif
                end else if (en) begin
                    state_d = S_RUN;
                end
            end
            S_FAULT: begin
                if (clear_fault) begin
                    state_d      = S_IDLE;
                    fault_code_d = 2'd0;
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef OSPFB_SEQ_WATCHDOG_EN
        // Counts cycles spent in DRAIN; restarts on every DRAIN entry
        if (state_q == S_DRAIN) begin
            wdog_d = wdog_q + WD_W'(1);
        end
        if ((state_d == S_DRAIN) && (state_q != S_DRAIN)) begin
            wdog_d = '0;
        end
`endif

        tvalid_d   = (state_d == S_CONFIG);
        ospfb_en_d = (state_d == S_RUN) || (state_d == S_DRAIN);
        busy_d     = (state_d != S_IDLE);
        fault_d    = (state_d == S_FAULT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            tdata_q       <= '0;
            tvalid_q      <= 1'b0;
            ospfb_en_q    <= 1'b0;
            busy_q        <= 1'b0;
            fault_q       <= 1'b0;
            fault_code_q  <= 2'd0;
            phase_q       <= '0;
            frame_count_q <= '0;
            ovf_count_q   <= '0;
`ifdef OSPFB_SEQ_WATCHDOG_EN
            wdog_q        <= '0;
`endif
        end else begin
            state_q       <= state_d;
            tdata_q       <= tdata_d;
            tvalid_q      <= tvalid_d;
            ospfb_en_q    <= ospfb_en_d;
            busy_q        <= busy_d;
            fault_q       <= fault_d;
            fault_code_q  <= fault_code_d;
            phase_q       <= phase_d;
            frame_count_q <= frame_count_d;
            ovf_count_q   <= ovf_count_d;
`ifdef OSPFB_SEQ_WATCHDOG_EN
            wdog_q        <= wdog_d;
`endif
        end
    end

    assign m_axis_cfg_tdata  = tdata_q;
    assign m_axis_cfg_tvalid = tvalid_q;
    assign ospfb_en          = ospfb_en_q;
    assign busy              = busy_q;
    assign fault             = fault_q;
    assign fault_code        = fault_code_q;
    assign phase             = phase_q;
    assign frame_count       = frame_count_q;
    assign ovf_count         = ovf_count_q;

endmodule

// File: tb/tb_ospfb_run_sequencer.sv
// Randomized scoreboard bench for ospfb_run_sequencer against a frame-count based reference model.
module tb_ospfb_run_sequencer;

    localparam int unsigned FFT_LEN  = 64;
    localparam int unsigned DEC_FAC  = 48;
    localparam int unsigned CONF_WID = 8;
    localparam int unsigned CNT_WID  = 32;
    localparam int unsigned OVF_WID  = 4;
    localparam int unsigned WDOG     = 16;
    localparam int unsigned PH_W     = $clog2(FFT_LEN);
    localparam int          OVF_MAX  = (1 << OVF_WID) - 1;

    localparam int M_IDLE = 0, M_CONFIG = 1, M_RUN = 2, M_DRAIN = 3, M_FAULT = 4;

    typedef struct packed {
        logic                tvalid;
        logic [CONF_WID-1:0] tdata;
        logic                ospfb_en;
        logic                busy;
        logic                fault;
        logic [1:0]          code;
        logic [PH_W-1:0]     phase;
        logic [CNT_WID-1:0]  frames;
        logic [OVF_WID-1:0]  ovf;
    } snap_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                en = 1'b0;
    logic [CONF_WID-1:0] cfg_word = '0;
    logic                clear_fault = 1'b0;
    logic [CONF_WID-1:0] m_axis_cfg_tdata;
    logic                m_axis_cfg_tvalid;
    logic                m_axis_cfg_tready = 1'b0;
    logic                ospfb_en;
    logic                mon_tvalid = 1'b0, mon_tready = 1'b0, mon_tlast = 1'b0;
    logic                event_fft_overflow = 1'b0;
    logic                event_tlast_unexpected = 1'b0, event_tlast_missing = 1'b0;
    logic                busy, fault;
    logic [1:0]          fault_code;
    logic [PH_W-1:0]     phase;
    logic [CNT_WID-1:0]  frame_count;
    logic [OVF_WID-1:0]  ovf_count;

    always #5 clk = ~clk;

    ospfb_run_sequencer #(
        .FFT_LEN(FFT_LEN), .DEC_FAC(DEC_FAC), .CONF_WID(CONF_WID),
        .CNT_WID(CNT_WID), .OVF_WID(OVF_WID), .WDOG_CYCLES(WDOG)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .cfg_word(cfg_word), .clear_fault(clear_fault),
        .m_axis_cfg_tdata(m_axis_cfg_tdata), .m_axis_cfg_tvalid(m_axis_cfg_tvalid),
        .m_axis_cfg_tready(m_axis_cfg_tready), .ospfb_en(ospfb_en),
        .mon_tvalid(mon_tvalid), .mon_tready(mon_tready), .mon_tlast(mon_tlast),
        .event_fft_overflow(event_fft_overflow),
        .event_tlast_unexpected(event_tlast_unexpected),
        .event_tlast_missing(event_tlast_missing),
        .busy(busy), .fault(fault), .fault_code(fault_code), .phase(phase),
        .frame_count(frame_count), .ovf_count(ovf_count)
    );

    int                  n_cmp = 0;
    int                  n_bad = 0;
    bit                  started = 1'b0;
    snap_t               exp_q[$];
    logic [CONF_WID-1:0] beat_q[$];

    // Reference model: mode plus counts; phase derived from frames since last configuration
    int                  m_mode, m_frames, m_ovf, m_code, m_dc;
    logic [CONF_WID-1:0] m_cfg;

    function automatic snap_t model_snap();
        snap_t s;
        s.tvalid   = (m_mode == M_CONFIG);
        s.tdata    = m_cfg;
        s.ospfb_en = (m_mode == M_RUN) || (m_mode == M_DRAIN);
        s.busy     = (m_mode != M_IDLE);
        s.fault    = (m_mode == M_FAULT);
        s.code     = 2'(m_code);
        s.phase    = PH_W'((m_frames * DEC_FAC) % FFT_LEN);
        s.frames   = CNT_WID'(m_frames);
        s.ovf      = OVF_WID'(m_ovf);
        return s;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_frames = 0; m_ovf = 0; m_code = 0; m_dc = 0; m_cfg = '0;
    endtask

    task automatic model_step();
        bit fe, fev;
        if (rst) begin
            model_reset();
            return;
        end
        fe  = mon_tvalid && mon_tready && mon_tlast;
        fev = event_tlast_unexpected || event_tlast_missing;
        if (event_fft_overflow && m_ovf < OVF_MAX) m_ovf++;
        case (m_mode)
            M_IDLE: if (en) begin m_mode = M_CONFIG; m_cfg = cfg_word; m_frames = 0; end
            M_CONFIG: if (m_axis_cfg_tready) begin beat_q.push_back(m_cfg); m_mode = M_RUN; end
            M_RUN: begin
                if (fev) begin
                    m_mode = M_FAULT; m_code = event_tlast_unexpected ? 1 : 2;
                end else begin
                    if (fe) m_frames++;
                    if (!en) begin m_mode = M_DRAIN; m_dc = 0; end
                end
            end
            M_DRAIN: begin
                if (fev) begin
                    m_mode = M_FAULT; m_code = event_tlast_unexpected ? 1 : 2;
                end else if (fe) begin
                    m_frames++; m_mode = M_IDLE;
                end else begin
                    m_dc++;
`ifdef OSPFB_SEQ_WATCHDOG_EN
                    if (m_dc >= WDOG) begin m_mode = M_FAULT; m_code = 3; end
                    else if (en) m_mode = M_RUN;
`else
                    if (en) m_mode = M_RUN;
`endif
                end
            end
            default: if (clear_fault) begin m_mode = M_IDLE; m_code = 0; end
        endcase
    endtask

    function automatic snap_t dut_snap();
        snap_t s;
        s.tvalid = m_axis_cfg_tvalid; s.tdata = m_axis_cfg_tdata; s.ospfb_en = ospfb_en;
        s.busy = busy; s.fault = fault; s.code = fault_code; s.phase = phase;
        s.frames = frame_count; s.ovf = ovf_count;
        return s;
    endfunction

    // Per-cycle output monitor
    always begin
        @(posedge clk);
        #1;
        if (started) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL snapshot t=%0t: no expectation queued", $time);
            end else begin
                snap_t e, a;
                e = exp_q.pop_front();
                a = dut_snap();
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL snapshot t=%0t got vld=%b dat=%h en=%b busy=%b flt=%b code=%0d ph=%0d frm=%0d ovf=%0d exp vld=%b dat=%h en=%b busy=%b flt=%b code=%0d ph=%0d frm=%0d ovf=%0d",
                             $time, a.tvalid, a.tdata, a.ospfb_en, a.busy, a.fault, a.code, a.phase, a.frames, a.ovf,
                             e.tvalid, e.tdata, e.ospfb_en, e.busy, e.fault, e.code, e.phase, e.frames, e.ovf);
                end
            end
        end
    end

    // Config beat monitor: a handshake is pending when valid and ready are both up before the edge
    always begin
        @(posedge clk);
        #3;
        if (started && !rst && m_axis_cfg_tvalid && m_axis_cfg_tready) begin
            n_cmp++;
            if (beat_q.size() == 0) begin
                n_bad++;
                $display("FAIL cfg_beat t=%0t: unexpected beat data=%h", $time, m_axis_cfg_tdata);
            end else begin
                logic [CONF_WID-1:0] eb;
                eb = beat_q.pop_front();
                if (m_axis_cfg_tdata !== eb) begin
                    n_bad++;
                    $display("FAIL cfg_beat t=%0t got=%h exp=%h", $time, m_axis_cfg_tdata, eb);
                end
            end
        end
    end

    initial begin
        int en_den, tlast_den, evt_den, ovf_den, rdy_den;
        snap_t z;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        z = '0;
        n_cmp++;
        if (dut_snap() !== z) begin
            n_bad++;
            $display("FAIL reset_state got=%h exp=%h", dut_snap(), z);
        end

        // Segments: normal run, framing faults, overflow-heavy, stalled frames for long drains
        for (int seg = 0; seg < 4; seg++) begin
            case (seg)
                0: begin en_den = 60;  tlast_den = 4;  evt_den = 0;   ovf_den = 0; rdy_den = 4; end
                1: begin en_den = 40;  tlast_den = 6;  evt_den = 60;  ovf_den = 0; rdy_den = 2; end
                2: begin en_den = 30;  tlast_den = 5;  evt_den = 150; ovf_den = 3; rdy_den = 2; end
                default: begin en_den = 80; tlast_den = 0; evt_den = 0; ovf_den = 0; rdy_den = 2; end
            endcase
            for (int cyc = 0; cyc < 900; cyc++) begin
                @(posedge clk);
                #2;
                rst                    = ($urandom_range(0, 699) == 0);
                if ($urandom_range(0, en_den - 1) == 0) en = ~en;
                cfg_word               = CONF_WID'($urandom);
                clear_fault            = ($urandom_range(0, 7) == 0);
                m_axis_cfg_tready      = ($urandom_range(0, rdy_den - 1) == 0);
                mon_tvalid             = 1'($urandom);
                mon_tready             = 1'($urandom);
                mon_tlast              = (tlast_den != 0) && ($urandom_range(0, tlast_den - 1) == 0);
                event_fft_overflow     = (ovf_den != 0) && ($urandom_range(0, ovf_den - 1) == 0);
                event_tlast_unexpected = (evt_den != 0) && ($urandom_range(0, evt_den - 1) == 0);
                event_tlast_missing    = (evt_den != 0) && ($urandom_range(0, evt_den - 1) == 0);
                model_step();
                exp_q.push_back(model_snap());
                started = 1'b1;
            end
        end

        @(posedge clk);
        #4;
        started = 1'b0;
        n_cmp++;
        if (beat_q.size() != 0 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain_queues beats_left=%0d snaps_left=%0d exp=0", beat_q.size(), exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
